// File: rtl/gear_shift_controller_if.sv
// Purpose : signal bundle between the gear selector and its surroundings.
//           Raw driver inputs (keys, pedal, speed, DIP enable) travel towards
//           the controller; committed gear, shift status and the one-cycle
//           event pulses travel back.
// Modports:
//   slave  - the controller: consumes keys/brake/safe_en/speed, drives status
//   master - the environment: drives keys/brake/safe_en/speed, reads status
interface gear_shift_controller_if #(
  parameter int NUM_GEARS = 4,
  parameter int SPEED_W   = 8
);
  localparam int GW = (NUM_GEARS > 1) ? $clog2(NUM_GEARS) : 1;

  logic [NUM_GEARS-1:0] key_gear;
  logic                 key_reset;
  logic                 brake;
  logic                 safe_en;
  logic [SPEED_W-1:0]   speed;

  logic [GW-1:0]        gear_idx;
  logic [NUM_GEARS-1:0] gear_onehot;
  logic                 shifting;
  logic                 shift_done;
  logic                 shift_reject;
  logic                 req_dropped;
  logic                 safe_rst_req;

  modport slave (
    input  key_gear, key_reset, brake, safe_en, speed,
    output gear_idx, gear_onehot, shifting, shift_done, shift_reject,
           req_dropped, safe_rst_req
  );

  modport master (
    output key_gear, key_reset, brake, safe_en, speed,
    input  gear_idx, gear_onehot, shifting, shift_done, shift_reject,
           req_dropped, safe_rst_req
  );
endinterface

// File: rtl/gear_shift_controller.sv
// Purpose : gear selector with speed/brake interlock, timed shift window and
//           a held-combo safe-reset request for downstream blocks.
//           Every raw key is synchronised and debounced; a debounced rising
//           edge becomes a one-cycle request, the lowest gear index wins.
// Ports   :
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - gear_shift_controller_if.slave (keys, brake, safe_en, speed in;
//            gear_idx, gear_onehot, shifting, shift_done, shift_reject,
//            req_dropped, safe_rst_req out)
//
// state  | meaning
// -------+---------------------------------------------------------------
// HOLD   | gear committed, requests arbitrated and interlock-checked
// SHIFT  | shift window running, target latched, new requests dropped
module gear_shift_controller #(
  parameter int NUM_GEARS       = 4,
  parameter int SPEED_W         = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SHIFT_DELAY     = 25000,
  parameter int SHIFT_SPEED_MAX = 5,
  parameter int RST_HOLD_CYCLES = 50000000
) (
  input logic                    clk,
  input logic                    rst_n,
  gear_shift_controller_if.slave bus
);

  localparam int NK   = NUM_GEARS + 1;  // gear keys plus the reset-combo key
  localparam int GW   = (NUM_GEARS > 1) ? $clog2(NUM_GEARS) : 1;
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SD_W = $clog2(SHIFT_DELAY) + 1;
  localparam int RH_W = $clog2(RST_HOLD_CYCLES) + 1;

  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SD_W-1:0]    SD_LAST = SD_W'(SHIFT_DELAY - 1);
  localparam logic [RH_W-1:0]    RH_LAST = RH_W'(RST_HOLD_CYCLES - 1);
  localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SHIFT_SPEED_MAX);

  localparam logic [0:0] ST_HOLD  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // ---------------------------------------------------------------- input path
  logic [NK-1:0]   raw_keys;
  logic [NK-1:0]   sync1;
  logic [NK-1:0]   sync2;
  logic [NK-1:0]   stable;
  logic [NK-1:0]   stable_q;
  logic [DB_W-1:0] db_cnt [NK];

  assign raw_keys = {bus.key_reset, bus.key_gear};

  // A level change is accepted once the synchronised input has disagreed with
  // the accepted level for DEBOUNCE_CYCLES consecutive cycles; any agreeing
  // cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int k = 0; k < NK; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync1    <= raw_keys;
      sync2    <= sync1;
      stable_q <= stable;
      for (int k = 0; k < NK; k++) begin
        if (sync2[k] != stable[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            stable[k] <= ~stable[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 1'b1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  logic [NUM_GEARS-1:0] req;
  logic                 key_rst_lvl;

  // Only rising edges of the debounced level request a shift.
  assign req         = stable[NUM_GEARS-1:0] & ~stable_q[NUM_GEARS-1:0];
  assign key_rst_lvl = stable[NUM_GEARS];

  // ---------------------------------------------------------------- arbitration
  logic          arb_valid;
  logic [GW-1:0] arb_idx;
  logic          arb_park_rev;

  // Scanned from the top so the lowest set index is the one left standing.
  always_comb begin
    arb_valid    = 1'b0;
    arb_idx      = '0;
    arb_park_rev = 1'b0;
    for (int i = NUM_GEARS - 1; i >= 0; i--) begin
      if (req[i]) begin
        arb_valid    = 1'b1;
        arb_idx      = GW'(i);
        arb_park_rev = (i < 2);
      end
    end
  end

  // ---------------------------------------------------------------- shift FSM
  logic [0:0]           state;
  logic [GW-1:0]        gear_idx;
  logic [NUM_GEARS-1:0] gear_onehot;
  logic [GW-1:0]        target;
  logic [SD_W-1:0]      shift_cnt;
  logic                 shift_done;
  logic                 shift_reject;
  logic                 req_dropped;
  logic                 interlock_ok;

  assign interlock_ok = (bus.speed <= SPD_MAX) && bus.brake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HOLD;
      gear_idx     <= '0;
      gear_onehot  <= NUM_GEARS'(1);
      target       <= '0;
      shift_cnt    <= '0;
      shift_done   <= 1'b0;
      shift_reject <= 1'b0;
      req_dropped  <= 1'b0;
    end else begin
      shift_done   <= 1'b0;
      shift_reject <= 1'b0;
      req_dropped  <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (arb_valid && (arb_idx != gear_idx)) begin
            if (arb_park_rev && !interlock_ok) begin
              shift_reject <= 1'b1;
            end else begin
              target    <= arb_idx;
              shift_cnt <= '0;
              state     <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          // The latched target is kept; late requests are only reported.
          if (arb_valid) begin
            req_dropped <= 1'b1;
          end
          if (shift_cnt == SD_LAST) begin
            gear_idx    <= target;
            gear_onehot <= NUM_GEARS'(1) << target;
            shift_done  <= 1'b1;
            state       <= ST_HOLD;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  // ---------------------------------------------------------------- safe reset
  logic            combo;
  logic [RH_W-1:0] rh_cnt;
  logic            rst_armed;
  logic            safe_rst_req;

  assign combo = key_rst_lvl && bus.brake && bus.safe_en &&
                 (bus.speed == '0) && (gear_idx == '0) && (state == ST_HOLD);

  // One pulse per press: rst_armed is only restored once the debounced key
  // has been released, so a key kept down cannot fire again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rh_cnt       <= '0;
      rst_armed    <= 1'b1;
      safe_rst_req <= 1'b0;
    end else begin
      safe_rst_req <= 1'b0;
      if (!key_rst_lvl) begin
        rst_armed <= 1'b1;
      end
      if (!combo) begin
        rh_cnt <= '0;
      end else if (rst_armed) begin
        if (rh_cnt == RH_LAST) begin
          safe_rst_req <= 1'b1;
          rh_cnt       <= '0;
          rst_armed    <= 1'b0;
        end else begin
          rh_cnt <= rh_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.gear_idx     = gear_idx;
  assign bus.gear_onehot  = gear_onehot;
  assign bus.shifting     = (state == ST_SHIFT);
  assign bus.shift_done   = shift_done;
  assign bus.shift_reject = shift_reject;
  assign bus.req_dropped  = req_dropped;
  assign bus.safe_rst_req = safe_rst_req;

endmodule

// File: tb/tb_gear_shift_controller.sv
module tb_gear_shift_controller;

  localparam int NG  = 4;
  localparam int SW  = 8;
  localparam int DB  = 4;
  localparam int SD  = 3;
  localparam int SPM = 5;
  localparam int RH  = 8;

  logic clk;
  logic rst_n;

  gear_shift_controller_if #(.NUM_GEARS(NG), .SPEED_W(SW)) bus ();

  gear_shift_controller #(
    .NUM_GEARS(NG), .SPEED_W(SW), .DEBOUNCE_CYCLES(DB), .SHIFT_DELAY(SD),
    .SHIFT_SPEED_MAX(SPM), .RST_HOLD_CYCLES(RH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // Behavioural view: a key is "pressed" after its raw level (seen two cycles
  // late through the synchroniser) has differed from the accepted level for
  // DB cycles in a row; the press is visible to the selector one cycle later.
  bit m_d1 [NG+1];
  bit m_d2 [NG+1];
  bit m_lvl [NG+1];
  bit m_rose [NG+1];
  int m_run [NG+1];
  int m_gear, m_target, m_left, m_streak;
  bit m_busy, m_armed, m_done, m_rej, m_drop, m_safe;

  task automatic model_reset();
    for (int k = 0; k <= NG; k++) begin
      m_d1[k] = 0; m_d2[k] = 0; m_lvl[k] = 0; m_rose[k] = 0; m_run[k] = 0;
    end
    m_gear = 0; m_target = 0; m_left = 0; m_streak = 0;
    m_busy = 0; m_armed = 1;
    m_done = 0; m_rej = 0; m_drop = 0; m_safe = 0;
  endtask

  task automatic model_edge();
    bit [NG-1:0] reqs;
    bit          rl, combo, synced;
    bit [NG:0]   raw;
    int          t;
    for (int i = 0; i < NG; i++) reqs[i] = m_rose[i];
    rl    = m_lvl[NG];
    combo = rl && bus.brake && bus.safe_en && (int'(bus.speed) == 0) &&
            (m_gear == 0) && !m_busy;
    m_done = 0; m_rej = 0; m_drop = 0; m_safe = 0;
    if (m_busy) begin
      if (reqs != 0) m_drop = 1;
      m_left--;
      if (m_left == 0) begin
        m_gear = m_target; m_busy = 0; m_done = 1;
      end
    end else if (reqs != 0) begin
      t = 0;
      while (!reqs[t]) t++;
      if (t != m_gear) begin
        if (t < 2 && (int'(bus.speed) > SPM || !bus.brake)) m_rej = 1;
        else begin
          m_busy = 1; m_left = SD; m_target = t;
        end
      end
    end
    if (!combo) m_streak = 0;
    else if (m_armed) begin
      m_streak++;
      if (m_streak == RH) begin
        m_safe = 1; m_streak = 0; m_armed = 0;
      end
    end
    if (!rl) m_armed = 1;
    raw = {bus.key_reset, bus.key_gear};
    for (int k = 0; k <= NG; k++) begin
      synced    = m_d2[k];
      m_d2[k]   = m_d1[k];
      m_d1[k]   = raw[k];
      m_rose[k] = 0;
      if (synced != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_lvl[k]  = !m_lvl[k];
          m_run[k]  = 0;
          m_rose[k] = m_lvl[k];
        end
      end else m_run[k] = 0;
    end
  endtask

  // ------------------------------------------------------------ stepping
  int obs_done, obs_rej, obs_drop, obs_safe, obs_shift;

  task automatic step();
    logic [10:0] got, exp;
    logic [1:0]  g;
    logic [3:0]  oh;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    g   = 2'(m_gear);
    oh  = 4'(1 << m_gear);
    exp = {g, oh, m_busy, m_done, m_rej, m_drop, m_safe};
    got = {bus.gear_idx, bus.gear_onehot, bus.shifting, bus.shift_done,
           bus.shift_reject, bus.req_dropped, bus.safe_rst_req};
    check("cycle_model", 32'(got), 32'(exp));
    obs_done  += int'(bus.shift_done);
    obs_rej   += int'(bus.shift_reject);
    obs_drop  += int'(bus.req_dropped);
    obs_safe  += int'(bus.safe_rst_req);
    obs_shift += int'(bus.shifting);
  endtask

  task automatic drive(input logic [3:0] kg, input logic kr, input logic brk,
                       input logic sen, input logic [7:0] spd);
    bus.key_gear = kg; bus.key_reset = kr; bus.brake = brk;
    bus.safe_en = sen; bus.speed = spd;
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic [3:0] kg;
    logic       kr, brk, sen;
    logic [7:0] spd;
    int         cycles;
    int         e_gear, e_done, e_rej, e_drop, e_safe, e_shift;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] kg, input logic kr, input logic brk,
                     input logic sen, input logic [7:0] spd, input int cyc,
                     input int g, input int d, input int rj, input int dr,
                     input int sf, input int sh);
    vec_t v;
    v.kg = kg; v.kr = kr; v.brk = brk; v.sen = sen; v.spd = spd; v.cycles = cyc;
    v.e_gear = g; v.e_done = d; v.e_rej = rj; v.e_drop = dr; v.e_safe = sf; v.e_shift = sh;
    tbl.push_back(v);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 8'd0);
    model_reset();

    //   kg       kr brk sen spd  cyc gear done rej drop safe shift
    add(4'b0100, 0, 1, 0, 8'd0,  10, 2, 1, 0, 0, 0, 3);  // plain shift to gear 2
    add(4'b0000, 0, 1, 0, 8'd0,   8, 2, 0, 0, 0, 0, 0);  // release: no request
    add(4'b1000, 0, 1, 0, 8'd0,   3, 2, 0, 0, 0, 0, 0);  // 3-cycle glitch
    add(4'b0000, 0, 1, 0, 8'd0,   8, 2, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 1, 0, 8'd0,   2, 2, 0, 0, 0, 0, 0);  // bounce 1-0-1
    add(4'b0000, 0, 1, 0, 8'd0,   1, 2, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 1, 0, 8'd0,  12, 3, 1, 0, 0, 0, 3);
    add(4'b0000, 0, 1, 0, 8'd0,   8, 3, 0, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 0, 8'd20, 10, 3, 0, 1, 0, 0, 0);  // reverse too fast
    add(4'b0000, 0, 1, 0, 8'd20,  8, 3, 0, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 0, 8'd5,  10, 1, 1, 0, 0, 0, 3);  // speed at limit
    add(4'b0000, 0, 1, 0, 8'd0,   8, 1, 0, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 0, 8'd0,  10, 1, 0, 1, 0, 0, 0);  // park without brake
    add(4'b0000, 0, 1, 0, 8'd0,   8, 1, 0, 0, 0, 0, 0);
    add(4'b0001, 0, 1, 0, 8'd0,  10, 0, 1, 0, 0, 0, 3);
    add(4'b0000, 0, 1, 0, 8'd0,   8, 0, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 1, 0, 8'd0,   2, 0, 0, 0, 0, 0, 0);  // key 3, key 2 lands mid-window
    add(4'b1100, 0, 1, 0, 8'd0,  12, 3, 1, 0, 1, 0, 3);
    add(4'b0000, 0, 1, 0, 8'd0,   8, 3, 0, 0, 0, 0, 0);
    add(4'b0001, 0, 1, 0, 8'd0,  10, 0, 1, 0, 0, 0, 3);
    add(4'b0000, 0, 1, 0, 8'd0,   8, 0, 0, 0, 0, 0, 0);
    add(4'b1100, 0, 1, 0, 8'd0,  10, 2, 1, 0, 0, 0, 3);  // same-cycle 2 and 3
    add(4'b0000, 0, 1, 0, 8'd0,   8, 2, 0, 0, 0, 0, 0);
    add(4'b0001, 0, 1, 0, 8'd0,  10, 0, 1, 0, 0, 0, 3);
    add(4'b0000, 0, 1, 0, 8'd0,   8, 0, 0, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 1, 8'd0,  30, 0, 0, 0, 0, 1, 0);  // safe combo held
    add(4'b0000, 0, 1, 1, 8'd0,  10, 0, 0, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 1, 8'd0,  30, 0, 0, 0, 0, 1, 0);  // re-press fires again
    add(4'b0000, 0, 1, 1, 8'd0,  10, 0, 0, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 1, 8'd1,  30, 0, 0, 0, 0, 0, 0);  // moving: no pulse
    add(4'b0000, 0, 1, 1, 8'd0,  10, 0, 0, 0, 0, 0, 0);
    add(4'b0000, 1, 1, 0, 8'd0,  30, 0, 0, 0, 0, 0, 0);  // DIP disabled
    add(4'b0000, 0, 1, 0, 8'd0,  10, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("in_reset_gear", 32'(bus.gear_idx), 32'd0);
    check("in_reset_onehot", 32'(bus.gear_onehot), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 32'({bus.gear_idx, bus.gear_onehot, bus.shifting, bus.shift_done,
                              bus.shift_reject, bus.req_dropped, bus.safe_rst_req}),
          32'({2'd0, 4'b0001, 5'b00000}));
    // that negedge had no model step; keep the model aligned with one idle edge
    model_edge();

    foreach (tbl[r]) begin
      drive(tbl[r].kg, tbl[r].kr, tbl[r].brk, tbl[r].sen, tbl[r].spd);
      obs_done = 0; obs_rej = 0; obs_drop = 0; obs_safe = 0; obs_shift = 0;
      for (int c = 0; c < tbl[r].cycles; c++) step();
      check($sformatf("vec%0d_gear", r),   32'(bus.gear_idx), 32'(tbl[r].e_gear));
      check($sformatf("vec%0d_done", r),   32'(obs_done),     32'(tbl[r].e_done));
      check($sformatf("vec%0d_reject", r), 32'(obs_rej),      32'(tbl[r].e_rej));
      check($sformatf("vec%0d_dropped", r), 32'(obs_drop),    32'(tbl[r].e_drop));
      check($sformatf("vec%0d_safe", r),   32'(obs_safe),     32'(tbl[r].e_safe));
      check($sformatf("vec%0d_shiftcyc", r), 32'(obs_shift),  32'(tbl[r].e_shift));
    end

    // Safe-reset pulse position: exactly RH cycles after the debounced rise,
    // i.e. 2 sync + DB debounce + RH hold edges after the key goes down.
    drive(4'b0000, 1'b1, 1'b1, 1'b1, 8'd0);
    obs_safe = 0;
    w = 0;
    while (obs_safe == 0 && w < 40) begin
      step();
      w++;
    end
    check("safe_pulse_latency", 32'(w), 32'(2 + DB + RH));
    drive(4'b0000, 1'b0, 1'b1, 1'b1, 8'd0);
    for (int c = 0; c < 10; c++) step();

    // Async reset in the middle of a shift window.
    drive(4'b1000, 1'b0, 1'b1, 1'b0, 8'd0);
    w = 0;
    while (bus.shifting !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("midshift_reached", 32'(bus.shifting), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midshift_rst_outputs",
          32'({bus.gear_idx, bus.gear_onehot, bus.shifting, bus.shift_done,
               bus.shift_reject, bus.req_dropped, bus.safe_rst_req}),
          32'({2'd0, 4'b0001, 5'b00000}));
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    obs_done = 0;
    for (int c = 0; c < 12; c++) step();
    check("midshift_no_done", 32'(obs_done), 32'd0);
    check("midshift_gear_park", 32'(bus.gear_idx), 32'd0);

    // Randomised traffic against the model.
    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] kg;
      logic [7:0] spd;
      int         n;
      kg  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      spd = ($urandom_range(0, 7) == 7) ? 8'd20 : 8'($urandom_range(0, 6));
      drive(kg, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), spd);
      n = $urandom_range(1, 12);
      for (int c = 0; c < n; c++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
